// File: rtl/data_mem_responder.sv
// Word data memory behind a req/ack handshake. Ack pulses LATENCY cycles after acceptance, and stall_o freezes the pipeline
// until then. Build with DMEM_BYTE_EN_EN to add the be_i per-byte store enables.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]  be_i,
`endif
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  BUSY_LOAD  = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           we_q;
  logic           fault_q;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wdata_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic           fault_in;
  logic           go_resp;
  logic           commit;
  logic           cur_we;
  logic           cur_fault;
  logic [AW-1:0]  cur_idx;
  logic [31:0]    cur_wdata;
  logic [3:0]     cur_be;

  assign fault_in = (addr_i[1:0] != 2'b00) || (addr_i >= ADDR_LIMIT);
  assign stall_o  = ((state == IDLE) && req_i) || (state == BUSY);

  // With LATENCY==1 the access completes on its accepting edge, so the live inputs are used then.
  assign go_resp = ((state == IDLE) && req_i && (LATENCY == 1)) ||
                   ((state == BUSY) && (cnt == 4'd0));

  always_comb begin
    cur_we    = we_q;
    cur_fault = fault_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_we    = we_i;
      cur_fault = fault_in;
      cur_idx   = addr_i[AW+1:2];
      cur_wdata = wdata_i;
    end
  end

`ifdef DMEM_BYTE_EN_EN
  logic [3:0] be_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      be_q <= 4'h0;
    end else if ((state == IDLE) && req_i) begin
      be_q <= be_i;
    end
  end

  assign cur_be = (state == IDLE) ? be_i : be_q;
`else
  assign cur_be = 4'hF;
`endif

  // Gated by reset so an abort can never leak a write into storage.
  assign commit = rst_n_i && go_resp && cur_we && !cur_fault;

  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) begin
          mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
      case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            fault_q <= fault_in;
            idx_q   <= addr_i[AW+1:2];
            wdata_q <= wdata_i;
            cnt     <= BUSY_LOAD;
            state   <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        ack_o   <= 1'b1;
        err_o   <= cur_fault;
        rdata_o <= (!cur_we && !cur_fault) ? mem[cur_idx] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder: driver queues expected acks, a monitor checks them.
module tb_data_mem_responder;

  localparam int L  = 3;
  localparam int D  = 256;
  localparam int AW = $clog2(D);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]  be = 4'hF;
`endif
  logic        ack;
  logic        err;
  logic        stall;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(D), .LATENCY(L)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
`ifdef DMEM_BYTE_EN_EN
    .be_i    (be),
`endif
    .ack_o   (ack),
    .rdata_o (rdata),
    .err_o   (err),
    .stall_o (stall)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    longint      t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [D];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && ack) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_ack: got ack with nothing outstanding at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("err", 32'(err), 32'(e.err));
        chk("ack_time", 32'($time), 32'(e.t));
      end
    end
  end

  // b2b: called at the previous ack's negedge with req still high; hold: leave req high after ack.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                        input bit drop, input bit b2b, input bit hold);
    bit          fault;
    bit          done;
    int          ns;
    int          acc_i;
    logic [3:0]  m;
    logic [31:0] rd;
    exp_t        e;
    if (!b2b) @(negedge clk);
    we = w; addr = a; wdata = d; req = 1'b1;
`ifdef DMEM_BYTE_EN_EN
    be = b;
    m  = b;
`else
    m  = 4'hF | b;
`endif
    fault = (a[1:0] != 2'b00) || (a >= 32'(4 * D));
    rd = 32'd0;
    if (!fault && !w) rd = model[a[AW+1:2]];
    if (!fault && w) begin
      for (int k = 0; k < 4; k++) if (m[k]) model[a[AW+1:2]][8*k +: 8] = d[8*k +: 8];
    end
    e.rdata = rd;
    e.err   = fault;
    e.t     = $time + (b2b ? (L + 1) * 10 : L * 10);
    q.push_back(e);
    #1 ns = stall ? 1 : 0;
    acc_i = b2b ? 1 : 0;
    done  = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ack) begin
        done = 1;
        chk("stall_in_resp", 32'(stall), 32'd0);
        chk("stall_cycles", 32'(ns), 32'(L));
      end else begin
        if (stall) ns++;
        if (i == acc_i) begin
          we = $urandom_range(0, 1) == 1;
          addr = $urandom;
          wdata = $urandom;
          if (drop) req = 1'b0;
        end
      end
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL ack_timeout: no ack within 40 cycles for addr %h", a);
      req = 1'b0;
    end else if (!hold) begin
      req = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bit          prev_hold;
    bit          hold;

    #2;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall_idle", 32'(stall), 32'd0);
    req = 1'b1;
    #1 chk("rst_stall_req", 32'(stall), 32'd1);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < D; i++) access(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 0, 0);

    access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    access(1'b0, 32'h10, 32'h0, 4'hF, 0, 0, 0);

    access(1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 0, 0, 1);
    access(1'b0, 32'h14, 32'h0, 4'hF, 0, 1, 1);
    access(1'b0, 32'h10, 32'h0, 4'hF, 0, 1, 0);

    access(1'b0, 32'h13, 32'h0, 4'hF, 0, 0, 0);
    access(1'b1, 32'h400, 32'h55555555, 4'hF, 0, 0, 0);
    access(1'b0, 32'h0, 32'h0, 4'hF, 0, 0, 0);

    // Reset lands in the second BUSY cycle: no ack may appear and storage keeps its old word.
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    access(1'b0, 32'h20, 32'h0, 4'hF, 0, 0, 0);

    access(1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, 1, 0, 0);
    access(1'b0, 32'h8, 32'h0, 4'hF, 0, 0, 0);

`ifdef DMEM_BYTE_EN_EN
    access(1'b1, 32'h0, 32'h11223344, 4'hF, 0, 0, 0);
    access(1'b1, 32'h0, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    access(1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    access(1'b1, 32'h0, 32'h99999999, 4'b0000, 0, 0, 0);
    access(1'b0, 32'h0, 32'h0, 4'hF, 0, 0, 0);
`endif

    prev_hold = 0;
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'(($urandom_range(0, D - 1) << 2) | $urandom_range(1, 3));
      else if (r == 1) a = $urandom | 32'h400;
      else             a = 32'($urandom_range(0, D - 1) << 2);
      hold = (i != 199) && ($urandom_range(0, 3) == 0);
      access($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 4) == 0, prev_hold, hold);
      prev_hold = hold;
    end

    repeat (5) @(negedge clk);
    chk("pending_acks", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
